// File: rtl/xg_mac_tx_arbiter.sv
// Frame-level round-robin arbiter muxing NUM_PORTS AXI-Stream sources onto one MAC TX stream.
// Latency 1 cycle (registered output); source ready follows output-register drain, so downstream stalls reach the granted port combinationally.
module xg_mac_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_BITS = 64,
    parameter int KEEP_BITS = 8
) (
    input  logic                           clock,
    input  logic                           aresetn,
    input  logic [NUM_PORTS*DATA_BITS-1:0] saxis_tdata,
    input  logic [NUM_PORTS*KEEP_BITS-1:0] saxis_tkeep,
    input  logic [NUM_PORTS-1:0]           saxis_tuser,
    input  logic [NUM_PORTS-1:0]           saxis_tlast,
    input  logic [NUM_PORTS-1:0]           saxis_tvalid,
    output logic [NUM_PORTS-1:0]           saxis_tready,
    output logic [DATA_BITS-1:0]           maxis_tdata,
    output logic [KEEP_BITS-1:0]           maxis_tkeep,
    output logic                           maxis_tuser,
    output logic                           maxis_tlast,
    output logic                           maxis_tvalid,
    input  logic                           maxis_tready,
    output logic [NUM_PORTS-1:0]           grant,
    output logic                           busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_rr_ptr;
    logic [PW-1:0]          r_gidx;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [DATA_BITS-1:0]   r_tdata;
    logic [KEEP_BITS-1:0]   r_tkeep;
    logic                   r_tuser;
    logic                   r_tlast;
    logic                   r_tvalid;

    logic                   w_out_free;
    logic                   w_acc;
    logic                   w_found;
    logic [PW-1:0]          w_idx;
    logic [PW-1:0]          w_cand;

    assign w_out_free   = !r_tvalid || maxis_tready;
    // r_grant is all-zero outside LOCKED, so this also forces ready low in IDLE and reset.
    assign saxis_tready = r_grant & {NUM_PORTS{w_out_free}};
    assign w_acc        = (r_state == S_LOCKED) && saxis_tvalid[r_gidx] && w_out_free;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = PW'((int'(r_rr_ptr) + i) % NUM_PORTS);
            if (!w_found && saxis_tvalid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_acc) begin
                r_tdata  <= saxis_tdata[r_gidx*DATA_BITS +: DATA_BITS];
                r_tkeep  <= saxis_tkeep[r_gidx*KEEP_BITS +: KEEP_BITS];
                r_tuser  <= saxis_tuser[r_gidx];
                r_tlast  <= saxis_tlast[r_gidx];
                r_tvalid <= 1'b1;
            end else if (maxis_tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_LOCKED;
                        r_gidx  <= w_idx;
                        r_grant <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_idx;
                    end
                end
                S_LOCKED: begin
                    if (w_acc && saxis_tlast[r_gidx]) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= (r_gidx == PW'(NUM_PORTS-1)) ? '0 : r_gidx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign maxis_tdata  = r_tdata;
    assign maxis_tkeep  = r_tkeep;
    assign maxis_tuser  = r_tuser;
    assign maxis_tlast  = r_tlast;
    assign maxis_tvalid = r_tvalid;
    assign grant        = r_grant;
    assign busy         = (r_state == S_LOCKED);

endmodule

// File: tb/tb_xg_mac_tx_arbiter.sv
// Directed bench for xg_mac_tx_arbiter: per-port frame sources, output beat log, hand-written expected orders.
module tb_xg_mac_tx_arbiter;

    localparam int NP = 4;
    localparam int DB = 64;
    localparam int KB = 8;

    logic              clock = 1'b0;
    logic              aresetn;
    logic [NP*DB-1:0]  saxis_tdata;
    logic [NP*KB-1:0]  saxis_tkeep;
    logic [NP-1:0]     saxis_tuser;
    logic [NP-1:0]     saxis_tlast;
    logic [NP-1:0]     saxis_tvalid;
    logic [NP-1:0]     saxis_tready;
    logic [DB-1:0]     maxis_tdata;
    logic [KB-1:0]     maxis_tkeep;
    logic              maxis_tuser;
    logic              maxis_tlast;
    logic              maxis_tvalid;
    logic              maxis_tready;
    logic [NP-1:0]     grant;
    logic              busy;

    xg_mac_tx_arbiter #(.NUM_PORTS(NP), .DATA_BITS(DB), .KEEP_BITS(KB)) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .saxis_tdata  (saxis_tdata),
        .saxis_tkeep  (saxis_tkeep),
        .saxis_tuser  (saxis_tuser),
        .saxis_tlast  (saxis_tlast),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tready (saxis_tready),
        .maxis_tdata  (maxis_tdata),
        .maxis_tkeep  (maxis_tkeep),
        .maxis_tuser  (maxis_tuser),
        .maxis_tlast  (maxis_tlast),
        .maxis_tvalid (maxis_tvalid),
        .maxis_tready (maxis_tready),
        .grant        (grant),
        .busy         (busy)
    );

    initial forever #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Source state: frames remaining, frame length, current beat, frame counter.
    int rem [NP];
    int flen[NP];
    int beat[NP];
    int fc  [NP];

    function automatic logic [63:0] enc(input int p, input int f, input int b);
        return 64'(p * 4096 + f * 16 + b);
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            saxis_tvalid[p]          = (rem[p] > 0);
            saxis_tdata[p*DB +: DB]  = enc(p, fc[p], beat[p]);
            saxis_tkeep[p*KB +: KB]  = 8'(8'hFF >> beat[p]);
            saxis_tuser[p]           = beat[p][0];
            saxis_tlast[p]           = (beat[p] == flen[p] - 1);
        end
    endtask

    task automatic load(input int p, input int n, input int len);
        rem[p]  = n;
        flen[p] = len;
        drive();
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            rem[p] = 0; flen[p] = 1; beat[p] = 0; fc[p] = 0;
        end
        drive();
    endtask

    function automatic bit src_idle();
        int s;
        s = 0;
        for (int p = 0; p < NP; p++) s += rem[p];
        return (s == 0);
    endfunction

    // Sources advance on handshakes seen mid-cycle.
    initial begin
        logic [NP-1:0] hs;
        forever begin
            @(negedge clock);
            hs = saxis_tvalid & saxis_tready;
            @(posedge clock);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && rem[p] > 0) begin
                    if (beat[p] == flen[p] - 1) begin
                        beat[p] = 0; fc[p]++; rem[p]--;
                    end else begin
                        beat[p]++;
                    end
                end
            end
            drive();
        end
    end

    logic [63:0] obs_dat[$];
    logic        obs_last[$];
    logic        obs_usr[$];
    int          obs_cyc[$];
    int          cyc  = 0;
    int          viol = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (aresetn && maxis_tvalid && maxis_tready) begin
            obs_dat.push_back(maxis_tdata);
            obs_last.push_back(maxis_tlast);
            obs_usr.push_back(maxis_tuser);
            obs_cyc.push_back(cyc);
        end
        if ((saxis_tready & ~grant) != '0 || $countones(grant) > 1 || busy != (grant != '0))
            viol++;
    end

    task automatic clear_obs();
        obs_dat.delete(); obs_last.delete(); obs_usr.delete(); obs_cyc.delete();
    endtask

    task automatic do_reset();
        aresetn      = 1'b0;
        maxis_tready = 1'b1;
        clear_src();
        clear_obs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        aresetn = 1'b1;
        @(posedge clock);
        #2;
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_dat.size() < n; i++) begin
            @(negedge clock);
            #1;
        end
        check("wait_obs", 64'(obs_dat.size() >= n), 64'(1));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !(src_idle() && !maxis_tvalid && !busy); i++) begin
            @(negedge clock);
            #1;
        end
        check("wait_done", 64'(src_idle() && !maxis_tvalid && !busy), 64'(1));
    endtask

    task automatic chk_seq(input string tag, input logic [63:0] e[$], input logic [15:0] lastmask);
        check({tag, "_count"}, 64'(obs_dat.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < obs_dat.size(); i++) begin
            check({tag, "_data"}, obs_dat[i], e[i]);
            check({tag, "_last"}, 64'(obs_last[i]), 64'(lastmask[i]));
        end
    endtask

    logic [63:0] e[$];

    initial begin
        aresetn      = 1'b1;
        maxis_tready = 1'b1;
        clear_src();
        #1 aresetn = 1'b0;
        #2;
        check("rst_grant",  64'(grant), 64'(0));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_mvalid", 64'(maxis_tvalid), 64'(0));
        check("rst_mdata",  maxis_tdata, 64'(0));
        check("rst_sready", 64'(saxis_tready), 64'(0));
        do_reset();

        // 1: single 3-beat frame from port 0
        load(0, 1, 3);
        @(negedge clock);
        check("t1_grant_idle",  64'(grant), 64'(0));
        check("t1_sready_idle", 64'(saxis_tready), 64'(0));
        @(negedge clock);
        check("t1_grant", 64'(grant), 64'(4'b0001));
        check("t1_busy",  64'(busy), 64'(1));
        check("t1_ready", 64'(saxis_tready), 64'(4'b0001));
        @(negedge clock);
        check("t1_first_valid", 64'(maxis_tvalid), 64'(1));
        check("t1_first_data",  maxis_tdata, enc(0, 0, 0));
        check("t1_first_keep",  64'(maxis_tkeep), 64'(8'hFF));
        wait_done(50);
        e = '{enc(0,0,0), enc(0,0,1), enc(0,0,2)};
        chk_seq("t1", e, 16'b100);
        check("t1_span",  64'(obs_cyc[2] - obs_cyc[0]), 64'(2));
        check("t1_tuser", 64'(obs_usr[1]), 64'(1));
        check("t1_grant_end", 64'(grant), 64'(0));

        // 2: ports 0 and 2 alternate
        do_reset();
        load(0, 2, 2);
        load(2, 2, 2);
        wait_done(100);
        e = '{enc(0,0,0), enc(0,0,1), enc(2,0,0), enc(2,0,1),
              enc(0,1,0), enc(0,1,1), enc(2,1,0), enc(2,1,1)};
        chk_seq("t2", e, 16'b10101010);
        check("t2_inframe", 64'(obs_cyc[1] - obs_cyc[0]), 64'(1));
        check("t2_idle_gap", 64'(obs_cyc[2] - obs_cyc[1]), 64'(2));

        // 3: all ports, one-beat frames, pointer wraps 3->0
        do_reset();
        for (int p = 0; p < NP; p++) load(p, 2, 1);
        wait_done(100);
        e = '{enc(0,0,0), enc(1,0,0), enc(2,0,0), enc(3,0,0),
              enc(0,1,0), enc(1,1,0), enc(2,1,0), enc(3,1,0)};
        chk_seq("t3", e, 16'b11111111);

        // 4: downstream stall for 3 cycles mid-frame
        do_reset();
        load(0, 1, 6);
        wait_obs(2, 50);
        @(posedge clock);
        #2 maxis_tready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t4_hold_valid", 64'(maxis_tvalid), 64'(1));
            check("t4_hold_data",  maxis_tdata, enc(0, 0, 2));
            check("t4_sready",     64'(saxis_tready), 64'(0));
        end
        @(posedge clock);
        #2 maxis_tready = 1'b1;
        wait_done(50);
        e = '{enc(0,0,0), enc(0,0,1), enc(0,0,2), enc(0,0,3), enc(0,0,4), enc(0,0,5)};
        chk_seq("t4", e, 16'b100000);
        check("t4_resume", 64'(obs_cyc[5] - obs_cyc[2]), 64'(3));

        // 5: port 1 requests while port 0 holds the grant
        do_reset();
        load(0, 1, 5);
        wait_obs(1, 50);
        load(1, 1, 2);
        repeat (2) begin
            @(negedge clock);
            check("t5_sready1", 64'(saxis_tready[1]), 64'(0));
            check("t5_grant",   64'(grant), 64'(4'b0001));
        end
        wait_done(100);
        e = '{enc(0,0,0), enc(0,0,1), enc(0,0,2), enc(0,0,3), enc(0,0,4),
              enc(1,0,0), enc(1,0,1)};
        chk_seq("t5", e, 16'b1010000);

        // 6: reset mid-frame; pointer returns to port 0
        do_reset();
        load(0, 1, 1);
        wait_done(50);
        clear_obs();
        load(0, 1, 5);
        wait_obs(2, 50);
        load(1, 1, 1);
        @(negedge clock);
        aresetn = 1'b0;
        #1;
        check("t6_mvalid", 64'(maxis_tvalid), 64'(0));
        check("t6_grant",  64'(grant), 64'(0));
        check("t6_busy",   64'(busy), 64'(0));
        check("t6_sready", 64'(saxis_tready), 64'(0));
        @(posedge clock);
        #2;
        clear_src();
        clear_obs();
        @(negedge clock);
        aresetn = 1'b1;
        @(posedge clock);
        #2;
        load(0, 1, 2);
        load(1, 1, 1);
        wait_done(50);
        e = '{enc(0,0,0), enc(0,0,1), enc(1,0,0)};
        chk_seq("t6", e, 16'b110);

        check("protocol_violations", 64'(viol), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
